// File: rtl/hilo_ctrl.sv
// HI/LO controller for the EXE-stage mult/div unit: issues operations, holds
// operands, stalls EXE while the unit works, and writes results or aborts.
module hilo_ctrl #(
    parameter int unsigned WDOG_CYCLES = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_valid_in,
    input  logic [3:0]  exe_md_op_in,
    input  logic [1:0]  exe_mt_op_in,
    input  logic [31:0] exe_rs_in,
    input  logic [31:0] exe_rt_in,
    input  logic        wb_ClrStpJmp_in,
    input  logic        mult_complete_in,
    input  logic        div_complete_in,
    input  logic [63:0] mult_res_in,
    input  logic [63:0] div_res_in,
    input  logic        div_tready_in,
    output logic [3:0]  md_op_out,
    output logic [31:0] md_in0_out,
    output logic [31:0] md_in1_out,
    output logic        md_flush_out,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        md_busy_out,
    output logic        md_err_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    localparam logic [5:0] WDOG_LIM = 6'(WDOG_CYCLES);

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [3:0]  md_op_q;
    logic [31:0] in0_q;
    logic [31:0] in1_q;
    logic        flush_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        err_q;

    logic        md_req;
    logic        is_mult_op;
    logic        issue;
    logic        mt_req;
    logic        complete;
    logic [63:0] res;
    logic [5:0]  cnt_inc;
    logic        wdog_hit;

    always_comb begin
        md_req     = exe_valid_in & (|exe_md_op_in) & ~wb_ClrStpJmp_in;
        is_mult_op = |exe_md_op_in[1:0];
        issue      = (state_q == S_IDLE) & md_req & (is_mult_op | div_tready_in);
        mt_req     = (state_q == S_IDLE) & exe_valid_in & ~wb_ClrStpJmp_in & ~(|exe_md_op_in);
        complete   = ((state_q == S_MULT) & mult_complete_in) |
                     ((state_q == S_DIV)  & div_complete_in);
        res        = (state_q == S_MULT) ? mult_res_in : div_res_in;
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 6'd1;
        // Abort on the edge where the count of elapsed wait cycles reaches the limit.
        wdog_hit   = (cnt_inc >= WDOG_LIM);
        md_busy_out = ((state_q != S_IDLE) & ~complete) | ((state_q == S_IDLE) & md_req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            md_op_q <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
            flush_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        md_op_q <= exe_md_op_in;
                        in0_q   <= exe_rs_in;
                        in1_q   <= exe_rt_in;
                        cnt_q   <= '0;
                        state_q <= is_mult_op ? S_MULT : S_DIV;
                    end else if (mt_req) begin
                        if (exe_mt_op_in[0]) hi_q <= exe_rs_in;
                        if (exe_mt_op_in[1]) lo_q <= exe_rs_in;
                    end
                end
                S_MULT, S_DIV: begin
                    cnt_q <= cnt_inc;
                    // Flush beats a coincident completion; completion beats the watchdog.
                    if (wb_ClrStpJmp_in) begin
                        md_op_q <= '0;
                        flush_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (complete) begin
                        hi_q    <= res[63:32];
                        lo_q    <= res[31:0];
                        md_op_q <= '0;
                        state_q <= S_IDLE;
                    end else if (wdog_hit) begin
                        md_op_q <= '0;
                        flush_q <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    md_op_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign md_op_out    = md_op_q;
    assign md_in0_out   = in0_q;
    assign md_in1_out   = in1_q;
    assign md_flush_out = flush_q;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;
    assign md_err_out   = err_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: directed stimulus with a HI/LO scoreboard; a second
// instance with a short watchdog covers the forced-abort path.
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [3:0]  md_op;
    logic [1:0]  mt_op;
    logic [31:0] rs, rt;
    logic        wb;
    logic        mc, dc;
    logic [63:0] mres, dres;
    logic        tready;

    logic [3:0]  op_o,  w_op_o;
    logic [31:0] in0_o, w_in0_o, in1_o, w_in1_o;
    logic        fl_o,  w_fl_o;
    logic [31:0] hi_o,  w_hi_o, lo_o, w_lo_o;
    logic        bz_o,  w_bz_o;
    logic        er_o,  w_er_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    hilo_ctrl #(.WDOG_CYCLES(63)) dut (
        .clk(clk), .rst(rst), .exe_valid_in(valid), .exe_md_op_in(md_op),
        .exe_mt_op_in(mt_op), .exe_rs_in(rs), .exe_rt_in(rt),
        .wb_ClrStpJmp_in(wb), .mult_complete_in(mc), .div_complete_in(dc),
        .mult_res_in(mres), .div_res_in(dres), .div_tready_in(tready),
        .md_op_out(op_o), .md_in0_out(in0_o), .md_in1_out(in1_o),
        .md_flush_out(fl_o), .hi_out(hi_o), .lo_out(lo_o),
        .md_busy_out(bz_o), .md_err_out(er_o)
    );

    hilo_ctrl #(.WDOG_CYCLES(8)) dut_w (
        .clk(clk), .rst(rst), .exe_valid_in(valid), .exe_md_op_in(md_op),
        .exe_mt_op_in(mt_op), .exe_rs_in(rs), .exe_rt_in(rt),
        .wb_ClrStpJmp_in(wb), .mult_complete_in(mc), .div_complete_in(dc),
        .mult_res_in(mres), .div_res_in(dres), .div_tready_in(tready),
        .md_op_out(w_op_o), .md_in0_out(w_in0_o), .md_in1_out(w_in1_o),
        .md_flush_out(w_fl_o), .hi_out(w_hi_o), .lo_out(w_lo_o),
        .md_busy_out(w_bz_o), .md_err_out(w_er_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_hilo(input string tag);
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 64'd1, 64'd0);
        else check(tag, {hi_o, lo_o}, exp_q.pop_front());
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 1'b0; md_op = '0; mt_op = '0; rs = '0; rt = '0;
        wb = 1'b0; mc = 1'b0; dc = 1'b0; mres = '0; dres = '0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1; md_op = op; rs = a; rt = b;
        #1 check("issue_busy", 64'(bz_o), 64'd1);
        cyc();
        valid = 1'b0; md_op = '0;
        #1 check("op_held", 64'(op_o), 64'(op));
    endtask

    initial begin
        idle_inputs();
        tready = 1'b1;
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        check("rst_hilo",  {hi_o, lo_o}, 64'd0);
        check("rst_op",    64'(op_o), 64'd0);
        check("rst_in",    {in0_o, in1_o}, 64'd0);
        check("rst_flush", 64'(fl_o), 64'd0);
        check("rst_err",   64'(er_o), 64'd0);
        check("rst_busy",  64'(bz_o), 64'd0);

        // MULT -2 * 3, complete two cycles after issue
        exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
        cyc();
        issue(4'b0001, 32'hFFFFFFFE, 32'd3);
        check("mult_ops", {in0_o, in1_o}, {32'hFFFFFFFE, 32'd3});
        check("mult_busy_wait", 64'(bz_o), 64'd1);
        cyc();
        mc = 1'b1; mres = 64'hFFFFFFFF_FFFFFFFA;
        #1 check("mult_busy_done", 64'(bz_o), 64'd0);
        cyc();
        mc = 1'b0;
        #1 check_hilo("mult_hilo");
        check("mult_op_clr", 64'(op_o), 64'd0);

        // DIVU 7/2, 33 cycles in DIV
        exp_q.push_back({32'd1, 32'd3});
        issue(4'b1000, 32'd7, 32'd2);
        for (int i = 1; i <= 32; i++) begin
            if (op_o !== 4'b1000 || bz_o !== 1'b1) check("divu_hold", {56'd0, bz_o, 3'd0, op_o}, {56'd0, 1'b1, 3'd0, 4'b1000});
            cyc();
        end
        check("divu_hold_end", 64'(op_o), 64'b1000);
        dc = 1'b1; dres = {32'd1, 32'd3};
        #1 check("divu_busy_done", 64'(bz_o), 64'd0);
        cyc();
        dc = 1'b0;
        #1 check_hilo("divu_hilo");

        // DIV 100/7 held off by tready for 3 cycles
        exp_q.push_back({32'd2, 32'd14});
        tready = 1'b0; valid = 1'b1; md_op = 4'b0100; rs = 32'd100; rt = 32'd7;
        for (int i = 0; i < 3; i++) begin
            #1 check("tready_busy", 64'(bz_o), 64'd1);
            cyc();
            check("tready_noop", 64'(op_o), 64'd0);
        end
        tready = 1'b1;
        #1 check("tready_busy_go", 64'(bz_o), 64'd1);
        cyc();
        valid = 1'b0; md_op = '0;
        #1 check("tready_issued", 64'(op_o), 64'b0100);
        dc = 1'b1; dres = {32'd2, 32'd14};
        cyc();
        dc = 1'b0;
        #1 check_hilo("div_hilo");

        // Flush in the 5th DIV cycle: no write
        exp_q.push_back({32'd2, 32'd14});
        issue(4'b1000, 32'd9, 32'd4);
        for (int i = 1; i < 5; i++) cyc();
        wb = 1'b1;
        cyc();
        wb = 1'b0;
        #1 check("flush_pulse", 64'(fl_o), 64'd1);
        check("flush_op_clr", 64'(op_o), 64'd0);
        check("flush_idle", 64'(bz_o), 64'd0);
        check_hilo("flush_hilo");
        cyc();
        check("flush_one_cycle", 64'(fl_o), 64'd0);

        // Flush coincident with completion: flush wins
        exp_q.push_back({32'd2, 32'd14});
        issue(4'b1000, 32'd9, 32'd4);
        dc = 1'b1; dres = {32'd1, 32'd2}; wb = 1'b1;
        cyc();
        dc = 1'b0; wb = 1'b0;
        #1 check("flushc_pulse", 64'(fl_o), 64'd1);
        check_hilo("flushc_hilo");

        // md and mt both set: mt dropped; div completion ignored in MULT
        exp_q.push_back(64'h00000001_00000002);
        mt_op = 2'b11;
        issue(4'b0010, 32'hAAAA5555, 32'd1);
        mt_op = 2'b00;
        dc = 1'b1; dres = 64'hDEAD_BEEF_0000_0001;
        #1 check("other_unit_busy", 64'(bz_o), 64'd1);
        cyc();
        dc = 1'b0; mc = 1'b1; mres = 64'h00000001_00000002;
        cyc();
        mc = 1'b0;
        #1 check_hilo("multu_hilo");

        // MTHI then MTLO: no stall
        exp_q.push_back({32'h12345678, 32'h9ABCDEF0});
        valid = 1'b1; mt_op = 2'b01; rs = 32'h12345678;
        #1 check("mthi_busy", 64'(bz_o), 64'd0);
        cyc();
        mt_op = 2'b10; rs = 32'h9ABCDEF0;
        #1 check("mtlo_busy", 64'(bz_o), 64'd0);
        cyc();
        mt_op = 2'b01; rs = 32'h0BAD0BAD; wb = 1'b1;
        cyc();
        valid = 1'b0; mt_op = '0; wb = 1'b0;
        #1 check_hilo("mt_hilo");

        // Watchdog on the WDOG_CYCLES=8 instance
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1 check("wd_rst_err", 64'(w_er_o), 64'd0);
        valid = 1'b1; md_op = 4'b0001; rs = 32'd5; rt = 32'd6;
        cyc();
        valid = 1'b0; md_op = '0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            if (w_bz_o !== 1'b1 || w_fl_o !== 1'b0 || w_er_o !== 1'b0)
                check("wd_wait", {61'd0, w_bz_o, w_fl_o, w_er_o}, 64'b100);
            cyc();
        end
        check("wd_flush", 64'(w_fl_o), 64'd1);
        check("wd_err", 64'(w_er_o), 64'd1);
        check("wd_op_clr", 64'(w_op_o), 64'd0);
        check("wd_idle", 64'(w_bz_o), 64'd0);
        cyc(); cyc(); cyc();
        check("wd_flush_end", 64'(w_fl_o), 64'd0);
        check("wd_err_sticky", 64'(w_er_o), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1 check("wd_err_clr", 64'(w_er_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- Execute-stage controller directly upstream and downstream of the mult/div unit.
- Issues MULT/MULTU/DIV/DIVU operations with held operands and stalls EXE while the unit works.
- Captures the 64-bit result into the architectural HI/LO registers and serves MTHI/MTLO writes and HI/LO reads.
- Aborts an in-flight operation on a writeback flush.

Parameters:
- WDOG_CYCLES, 63: maximum wait cycles for completion before forced abort (1..63).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- exe_valid_in  in  1  valid instruction in EXE
- exe_md_op_in  in  4  one-hot {0:mult,1:multu,2:div,3:divu}
- exe_mt_op_in  in  2  one-hot {0:mthi,1:mtlo}
- exe_rs_in  in  32  rs operand
- exe_rt_in  in  32  rt operand
- wb_ClrStpJmp_in  in  1  writeback flush
- mult_complete_in  in  1  mult result valid this cycle
- div_complete_in  in  1  div result valid this cycle
- mult_res_in  in  64  {hi,lo} product
- div_res_in  in  64  {remainder[63:32], quotient[31:0]}
- div_tready_in  in  1  divider can accept an operation
- md_op_out  out  4  registered op to mult/div, held for the whole operation
- md_in0_out  out  32  latched rs
- md_in1_out  out  32  latched rt
- md_flush_out  out  1  one-cycle abort pulse to mult/div
- hi_out  out  32  HI register
- lo_out  out  32  LO register
- md_busy_out  out  1  EXE stall request
- md_err_out  out  1  sticky watchdog error

Behaviour:
- Reset (rst high at clk edge) applies from any state:
  - state=IDLE, hi/lo=0, md_op_out=0, md_in0/1_out=0, md_flush_out=0, md_err_out=0, counter=0.
- States: IDLE, MULT, DIV.
- Issue from IDLE requires exe_valid_in & |exe_md_op_in & !wb_ClrStpJmp_in.
  - Mult ops: issue unconditionally. Div ops: issue only if div_tready_in; otherwise remain in IDLE with md_busy_out=1.
  - On the issue edge: md_op_out<=exe_md_op_in, md_in0_out<=exe_rs_in, md_in1_out<=exe_rt_in, counter<=0, next state MULT (bits 0/1) or DIV (bits 2/3).
- MULT/DIV states:
  - md_op_out and the operands are held stable.
  - counter increments each cycle, saturating.
  - Completion is mult_complete_in in MULT, or div_complete_in in DIV.
  - On completion without flush: hi<=res[63:32], lo<=res[31:0], using mult_res_in or div_res_in respectively. Then md_op_out<=0 and state<=IDLE.
  - Completion of the other unit is ignored.
- md_busy_out is combinational:
  - (state!=IDLE & !completion) | (state==IDLE & exe_valid_in & |exe_md_op_in & !wb_ClrStpJmp_in).
  - busy is therefore 0 in the completion cycle, so the instruction leaves EXE on the same edge HI/LO is written; a following MFHI/MFLO sees the new value.
- Flush (wb_ClrStpJmp_in=1):
  - In IDLE: no issue, no MT write.
  - In MULT/DIV: state<=IDLE, md_op_out<=0, md_flush_out<=1 for one cycle, no HI/LO write.
  - Flush coincident with completion: flush wins, no write.
- Watchdog:
  - If counter reaches WDOG_CYCLES in MULT/DIV without completion: abort as for flush, and md_err_out<=1.
  - md_err_out is cleared only by rst.
- MTHI/MTLO:
  - Accepted only in IDLE with exe_valid_in & !wb_ClrStpJmp_in & !(|exe_md_op_in).
  - hi<=exe_rs_in (mthi) or lo<=exe_rs_in (mtlo) on the next edge. No stall.
  - Ignored in MULT/DIV.
- md_op and mt_op both set: md_op has priority, mt_op is dropped.
- hi_out/lo_out are the register values directly, with no bypass.

Test Plan:
- MULT: rs=0xFFFFFFFE, rt=3; stub asserts mult_complete_in 2 cycles after issue with mult_res_in=0xFFFFFFFF_FFFFFFFA -> busy high 2 cycles, low in completion cycle; next cycle hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFA.
- DIVU: rs=7, rt=2; div_complete_in after 33 cycles with div_res_in={32'd1,32'd3} -> md_op_out=4'b1000 held throughout; hi_out=1, lo_out=3.
- div_tready_in=0 for 3 cycles while DIV pending in EXE -> md_op_out stays 0 and busy=1; issue on the first tready=1 cycle.
- Flush in the 5th cycle of DIV -> md_flush_out pulses one cycle, state IDLE, HI/LO unchanged. Also flush coincident with div_complete_in -> no write.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 -> hi_out=0x12345678, lo_out=0x9ABCDEF0, busy never asserted.
- WDOG_CYCLES=8, no completion after MULT issue -> abort at the 8th wait cycle, md_flush_out pulse, md_err_out=1 until rst.
